// File: rtl/jump_issue_ctrl.sv
// In-order issue queue and sequencer for the jump/branch functional unit.
// Buffers dispatched ops, wakes operands off the CDB, issues the oldest ready op, handles redirect and link writeback.
module jump_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_disp_valid,
    output logic             o_disp_ready,
    input  logic             i_disp_jalr,
    input  logic             i_disp_uncond,
    input  logic [2:0]       i_disp_cmp_ctrl,
    input  logic [31:0]      i_disp_pc,
    input  logic [31:0]      i_disp_imm,
    input  logic [TAG_W-1:0] i_disp_rd_tag,
    input  logic             i_disp_rs1_rdy,
    input  logic [31:0]      i_disp_rs1_val,
    input  logic [TAG_W-1:0] i_disp_rs1_tag,
    input  logic             i_disp_rs2_rdy,
    input  logic [31:0]      i_disp_rs2_val,
    input  logic [TAG_W-1:0] i_disp_rs2_tag,
    input  logic             i_cdb_valid,
    input  logic [TAG_W-1:0] i_cdb_tag,
    input  logic [31:0]      i_cdb_data,
    output logic             o_fu_en,
    output logic             o_fu_jalr,
    output logic [2:0]       o_fu_cmp_ctrl,
    output logic [31:0]      o_fu_rs1,
    output logic [31:0]      o_fu_rs2,
    output logic [31:0]      o_fu_imm,
    output logic [31:0]      o_fu_pc,
    input  logic [31:0]      i_fu_pc_jump,
    input  logic [31:0]      i_fu_pc_wb,
    input  logic             i_fu_cmp_res,
    output logic             o_redirect_valid,
    output logic [31:0]      o_redirect_pc,
    output logic             o_wb_valid,
    output logic [TAG_W-1:0] o_wb_tag,
    output logic [31:0]      o_wb_data,
    input  logic             i_wb_ready,
    input  logic             i_flush
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   L_FULL    = DEPTH;
    localparam logic [PTR_W:0]   L_CNT_ONE = 1;
    localparam logic [PTR_W:0]   L_CNT_0   = 0;
    localparam logic [PTR_W-1:0] L_PTR_ONE = 1;
    localparam logic [PTR_W-1:0] L_PTR_0   = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t r_state;

    logic [DEPTH-1:0] r_jalr, r_uncond, r_rs1_rdy, r_rs2_rdy;
    logic [2:0]       r_cmp     [DEPTH];
    logic [31:0]      r_pc      [DEPTH];
    logic [31:0]      r_imm     [DEPTH];
    logic [31:0]      r_rs1     [DEPTH];
    logic [31:0]      r_rs2     [DEPTH];
    logic [TAG_W-1:0] r_rd_tag  [DEPTH];
    logic [TAG_W-1:0] r_rs1_tag [DEPTH];
    logic [TAG_W-1:0] r_rs2_tag [DEPTH];

    logic [PTR_W-1:0] r_head, r_tail;
    logic [PTR_W:0]   r_count;
    logic             r_exec_uncond;
    logic [TAG_W-1:0] r_exec_tag;

    logic w_push, w_issue, w_taken;
    logic w_d1_hit, w_d2_hit;

    assign o_disp_ready = (r_count != L_FULL) & ~o_redirect_valid & ~i_flush;
    assign w_push       = i_disp_valid & o_disp_ready;
    assign w_issue      = (r_state == S_IDLE) & (r_count != L_CNT_0) &
                          r_rs1_rdy[r_head] & r_rs2_rdy[r_head] & ~i_flush;
    assign w_taken      = r_exec_uncond | i_fu_cmp_res;
    // An operand broadcast in the dispatch cycle is captured directly so it cannot be missed.
    assign w_d1_hit     = ~i_disp_rs1_rdy & i_cdb_valid & (i_cdb_tag == i_disp_rs1_tag);
    assign w_d2_hit     = ~i_disp_rs2_rdy & i_cdb_valid & (i_cdb_tag == i_disp_rs2_tag);

    assign o_fu_en       = w_issue;
    assign o_fu_jalr     = r_jalr[r_head];
    assign o_fu_cmp_ctrl = r_cmp[r_head];
    assign o_fu_rs1      = r_rs1[r_head];
    assign o_fu_rs2      = r_rs2[r_head];
    assign o_fu_imm      = r_imm[r_head];
    assign o_fu_pc       = r_pc[r_head];

    // Queue storage, CDB wakeup and pointer/count maintenance.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head    <= L_PTR_0;
            r_tail    <= L_PTR_0;
            r_count   <= L_CNT_0;
            r_jalr    <= '0;
            r_uncond  <= '0;
            r_rs1_rdy <= '0;
            r_rs2_rdy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_cmp[i]     <= 3'd0;
                r_pc[i]      <= 32'd0;
                r_imm[i]     <= 32'd0;
                r_rs1[i]     <= 32'd0;
                r_rs2[i]     <= 32'd0;
                r_rd_tag[i]  <= '0;
                r_rs1_tag[i] <= '0;
                r_rs2_tag[i] <= '0;
            end
        end else if (i_flush) begin
            r_head  <= L_PTR_0;
            r_tail  <= L_PTR_0;
            r_count <= L_CNT_0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_cdb_valid && !r_rs1_rdy[i] && (r_rs1_tag[i] == i_cdb_tag)) begin
                    r_rs1_rdy[i] <= 1'b1;
                    r_rs1[i]     <= i_cdb_data;
                end
                if (i_cdb_valid && !r_rs2_rdy[i] && (r_rs2_tag[i] == i_cdb_tag)) begin
                    r_rs2_rdy[i] <= 1'b1;
                    r_rs2[i]     <= i_cdb_data;
                end
            end
            if (w_push) begin
                r_jalr[r_tail]    <= i_disp_jalr;
                r_uncond[r_tail]  <= i_disp_uncond;
                r_cmp[r_tail]     <= i_disp_cmp_ctrl;
                r_pc[r_tail]      <= i_disp_pc;
                r_imm[r_tail]     <= i_disp_imm;
                r_rd_tag[r_tail]  <= i_disp_rd_tag;
                r_rs1_rdy[r_tail] <= i_disp_rs1_rdy | w_d1_hit;
                r_rs2_rdy[r_tail] <= i_disp_rs2_rdy | w_d2_hit;
                r_rs1[r_tail]     <= i_disp_rs1_rdy ? i_disp_rs1_val : i_cdb_data;
                r_rs2[r_tail]     <= i_disp_rs2_rdy ? i_disp_rs2_val : i_cdb_data;
                r_rs1_tag[r_tail] <= i_disp_rs1_tag;
                r_rs2_tag[r_tail] <= i_disp_rs2_tag;
            end
            // Everything still queued is younger than a taken op, so it is discarded.
            if ((r_state == S_EXEC) && w_taken) begin
                r_head  <= L_PTR_0;
                r_tail  <= L_PTR_0;
                r_count <= L_CNT_0;
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + L_PTR_ONE;
                end else begin
                    r_tail <= r_tail;
                end
                if (w_issue) begin
                    r_head <= r_head + L_PTR_ONE;
                end else begin
                    r_head <= r_head;
                end
                if (w_push && !w_issue) begin
                    r_count <= r_count + L_CNT_ONE;
                end else if (!w_push && w_issue) begin
                    r_count <= r_count - L_CNT_ONE;
                end else begin
                    r_count <= r_count;
                end
            end
        end
    end

    // Issue/execute/writeback sequencer with registered redirect and writeback outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state          <= S_IDLE;
            r_exec_uncond    <= 1'b0;
            r_exec_tag       <= '0;
            o_redirect_valid <= 1'b0;
            o_redirect_pc    <= 32'd0;
            o_wb_valid       <= 1'b0;
            o_wb_tag         <= '0;
            o_wb_data        <= 32'd0;
        end else if (i_flush) begin
            r_state          <= S_IDLE;
            o_redirect_valid <= 1'b0;
            o_wb_valid       <= 1'b0;
        end else begin
            o_redirect_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_exec_uncond <= r_uncond[r_head];
                        r_exec_tag    <= r_rd_tag[r_head];
                        r_state       <= S_EXEC;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    if (w_taken) begin
                        o_redirect_valid <= 1'b1;
                        o_redirect_pc    <= i_fu_pc_jump;
                    end else begin
                        o_redirect_pc <= o_redirect_pc;
                    end
                    if (r_exec_uncond) begin
                        o_wb_valid <= 1'b1;
                        o_wb_tag   <= r_exec_tag;
                        o_wb_data  <= i_fu_pc_wb;
                        r_state    <= S_WB;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WB: begin
                    if (i_wb_ready) begin
                        o_wb_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    o_wb_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
